// File: rtl/fpau_sqrt_pkg.sv
// Shared constants and arithmetic primitives for the significand square-root datapath.
// Holds the FSM encoding, iteration count and the 26-bit two's-complement/adder cells.
package fpau_sqrt_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SQRT_ITER = 24;
  localparam int RAD_W     = 48;
  localparam int REM_W     = 26;

  function automatic logic [REM_W-1:0] tc26(input logic [REM_W-1:0] a);
    return ~a + REM_W'(1);
  endfunction

  // Result carries the adder carry-out in its MSB.
  function automatic logic [REM_W:0] adder26(input logic [REM_W-1:0] a,
                                             input logic [REM_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/sqrt_mant_iter_if.sv
// Request/result bundle between the unpack stage and the square-root engine.
interface sqrt_mant_iter_if #(parameter int WIDTH = 24);
  logic             start;
  logic [WIDTH-1:0] mant_in;
  logic             exp_odd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] root;
  logic             sticky;

  modport master (output start, mant_in, exp_odd,
                  input  busy, done, root, sticky);
  modport slave  (input  start, mant_in, exp_odd,
                  output busy, done, root, sticky);
endinterface

// File: rtl/sqrt_mant_iter_step.sv
// One restoring square-root iteration: trial-subtract {Q,01} from the shifted remainder.
// Purely combinational; the carry-out of T + tc(D) is the "non-negative" decision.
module sqrt_step
  import fpau_sqrt_pkg::*;
(
  input  logic [REM_W-3:0] rem,
  input  logic [1:0]       rad_bits,
  input  logic [REM_W-3:0] q,
  output logic [REM_W-1:0] rem_next,
  output logic             root_bit
);

  logic [REM_W-1:0] t;
  logic [REM_W-1:0] d;
  logic [REM_W:0]   sum;

  assign t        = {rem, rad_bits};
  assign d        = {q, 2'b01};
  assign sum      = adder26(t, tc26(d));
  assign root_bit = sum[REM_W];
  assign rem_next = root_bit ? sum[REM_W-1:0] : t;

endmodule

// File: rtl/sqrt_mant_iter.sv
// Sequential restoring square root of a 24-bit significand, one root bit per cycle.
// done pulses 24 edges after the start edge; root/sticky hold until the next completion.
module sqrt_mant_iter
  import fpau_sqrt_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
)(
  input  logic             clk,
  input  logic             rst,
  sqrt_mant_iter_if.slave  bus
);

  logic [1:0]       state;
  logic [RAD_W-1:0] rad;
  logic [REM_W-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] root_r;
  logic             sticky_r;

  logic [REM_W-1:0] rem_next;
  logic             root_bit;
  logic [WIDTH-1:0] q_next;

  // Before the last iteration the remainder is below 2^24, so only its low bits feed T.
  sqrt_step u_step (
    .rem      (rem[REM_W-3:0]),
    .rad_bits (rad[RAD_W-1:RAD_W-2]),
    .q        (q),
    .rem_next (rem_next),
    .root_bit (root_bit)
  );

  assign q_next = {q[WIDTH-2:0], root_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rad      <= '0;
      rem      <= '0;
      q        <= '0;
      cnt      <= '0;
      root_r   <= '0;
      sticky_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            // Odd exponent: radicand pre-doubled so the result exponent halves cleanly.
            rad   <= bus.exp_odd ? {bus.mant_in, {WIDTH{1'b0}}}
                                 : {1'b0, bus.mant_in, {(WIDTH-1){1'b0}}};
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          rem <= rem_next;
          q   <= q_next;
          rad <= {rad[RAD_W-3:0], 2'b00};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(SQRT_ITER - 1)) begin
            state    <= S_DONE;
            root_r   <= q_next;
            sticky_r <= |rem_next;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.root   = root_r;
  assign bus.sticky = sticky_r;

endmodule

// File: tb/tb_sqrt_mant_iter.sv
// Directed and random checks of sqrt_mant_iter against an integer square-root model.
module tb_sqrt_mant_iter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [23:0] prev_root;
  logic        prev_sticky;

  sqrt_mant_iter_if #(.WIDTH(24)) bus ();

  sqrt_mant_iter #(.WIDTH(24), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // floor(sqrt(R)) with R the radicand as an integer; sticky when R is not a perfect square.
  function automatic void model(input logic [23:0] m, input bit odd,
                                output logic [23:0] r, output bit s);
    longint rr;
    longint x;
    rr = odd ? (longint'(m) << 24) : (longint'(m) << 23);
    x  = longint'($rtoi($sqrt(real'(rr))));
    while (x * x > rr) x--;
    while ((x + 1) * (x + 1) <= rr) x++;
    r = x[23:0];
    s = (x * x != rr);
  endfunction

  task automatic run_op(input logic [23:0] m, input bit odd, input string tag);
    logic [23:0] er;
    bit          es;
    int          lat;
    model(m, odd, er, es);
    lat = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mant_in = m;
    bus.exp_odd = odd;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) begin
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_hold"}, 32'(bus.root), 32'(prev_root));
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"},    32'(lat),        32'd25);
    check({tag, "_root"},   32'(bus.root),   32'(er));
    check({tag, "_sticky"}, 32'(bus.sticky), 32'(es));
    @(negedge clk);
    check({tag, "_done_off"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    prev_root   = er;
    prev_sticky = es;
  endtask

  initial begin
    int          ndone;
    int          first;
    int          second;
    logic [23:0] rm;
    bit          ro;
    total       = 0;
    bad         = 0;
    prev_root   = '0;
    prev_sticky = 1'b0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.mant_in = '0;
    bus.exp_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_root",   32'(bus.root),   32'd0);
    check("rst_sticky", 32'(bus.sticky), 32'd0);
    rst = 1'b0;

    run_op(24'h800000, 1'b0, "one");
    check("one_const", 32'(bus.root), 32'h800000);
    run_op(24'h800000, 1'b1, "two");
    check("two_const", 32'(bus.root), 32'hB504F3);
    check("two_stk",   32'(bus.sticky), 32'd1);
    run_op(24'h900000, 1'b1, "x225");
    check("x225_const", 32'(bus.root), 32'hC00000);
    run_op(24'hFFFFFF, 1'b1, "max");
    check("max_const", 32'(bus.root), 32'hFFFFFF);
    run_op(24'h000000, 1'b0, "zero");
    run_op(24'h000001, 1'b1, "tiny");

    // Second start during CALC must be dropped.
    ndone = 0;
    first = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mant_in = 24'h800000; bus.exp_odd = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (i == 10) begin
        bus.start = 1'b1; bus.mant_in = 24'h900000; bus.exp_odd = 1'b1;
      end
      if (i == 25) check("ign_busy25", 32'(bus.busy), 32'd1);
      if (i == 26) check("ign_busy26", 32'(bus.busy), 32'd0);
      if (bus.done) begin
        ndone++;
        if (first == 0) first = i;
      end
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_lat",   32'(first), 32'd25);
    check("ign_root",  32'(bus.root), 32'hB504F3);
    prev_root = 24'hB504F3;

    // Start held high: back-to-back operations 26 cycles apart.
    first = 0; second = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mant_in = 24'h900000; bus.exp_odd = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 5) bus.mant_in = 24'hFFFFFF;
      if (bus.done) begin
        if (first == 0) begin
          first = i;
          check("held_root1", 32'(bus.root), 32'hC00000);
        end else if (second == 0) begin
          second = i;
          bus.start = 1'b0;
        end
      end
      if (second != 0) break;
    end
    bus.start = 1'b0;
    check("held_first",  32'(first), 32'd25);
    check("held_period", 32'(second - first), 32'd26);
    check("held_root2",  32'(bus.root), 32'hFFFFFF);
    check("held_stk2",   32'(bus.sticky), 32'd1);
    prev_root = 24'hFFFFFF;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.mant_in = 24'hC34567; bus.exp_odd = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_busy",   32'(bus.busy),   32'd0);
    check("mid_done",   32'(bus.done),   32'd0);
    check("mid_root",   32'(bus.root),   32'd0);
    check("mid_sticky", 32'(bus.sticky), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_root = '0;
    run_op(24'h800000, 1'b1, "post_rst");

    for (int n = 0; n < 300; n++) begin
      rm = 24'h800000 | 24'($urandom_range(24'h7FFFFF, 0));
      ro = 1'($urandom_range(1, 0));
      run_op(rm, ro, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
